// File: rtl/mstatus_trace_pkg.sv
// Shared types and field positions for the mstatus change tracker.
// Holds the record struct, tracker state enum and the legality helper.
package mstatus_trace_pkg;

    localparam int UIE_BIT   = 0;
    localparam int SIE_BIT   = 1;
    localparam int MIE_BIT   = 3;
    localparam int MPIE_BIT  = 7;
    localparam int SPP_BIT   = 8;
    localparam int MPP_LSB   = 11;
    localparam int MPP_MSB   = 12;
    localparam int MPRV_BIT  = 17;
    localparam int TSR_BIT   = 22;
    localparam int ZERO1_LSB = 23;
    localparam int ZERO1_MSB = 30;
    localparam int SD_BIT    = 31;

    localparam logic [31:0] WPRI_MASK = 32'h7F80_0000;
    localparam logic [1:0]  MPP_RSVD  = 2'b10;

    // Widest stamp a record can carry; narrower
    // stamps leave the upper bits at zero.
    localparam int STAMP_MAX_W = 64;

    typedef struct packed {
        logic [31:0]            old_st;
        logic [31:0]            new_st;
        logic [31:0]            mask;
        logic [1:0]             dprv;
        logic [STAMP_MAX_W-1:0] stamp;
    } mstatus_rec_t;

    typedef enum logic {
        IDLE,
        TRACK
    } trk_state_e;

    function automatic logic is_illegal(input logic [31:0] ms);
        return (ms[MPP_MSB:MPP_LSB] == MPP_RSVD) ||
               ((ms & WPRI_MASK) != 32'h0);
    endfunction

endpackage

// File: rtl/mstatus_trace_fifo.sv
// Synchronous FIFO of mstatus change records with push/pop/full/empty/level.
// Ports: clock, reset_n, flush, push, wdata, pop, rdata, full, empty, level.
module mstatus_trace_fifo
    import mstatus_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  mstatus_rec_t             wdata,
    input  logic                     pop,
    output mstatus_rec_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    mstatus_rec_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

    // A full FIFO still takes a write when a read frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && reset_n && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Zero when empty so the record outputs never show stale data.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mstatus_change_tracker.sv
// Tracks changes in watched mstatus fields and dprv, queueing stamped records.
// Ports: clock/reset_n/flush, sample_* in, rec_* valid/ready out, level/drops.
// Optional legality check enabled by MSTATUS_TRACE_LEGAL_CHECK_EN.
module mstatus_change_tracker
    import mstatus_trace_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          STAMP_W    = 32,
    parameter logic [31:0] WATCH_MASK = 32'h007F_FFFF,
    parameter int          DROP_W     = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       sample_valid,
    input  logic [31:0]                mstatus_in,
    input  logic [1:0]                 dprv_in,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [31:0]                rec_old,
    output logic [31:0]                rec_new,
    output logic [31:0]                rec_mask,
    output logic [1:0]                 rec_dprv,
    output logic [STAMP_W-1:0]         rec_stamp,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       illegal_seen
);

    trk_state_e          state_q;
    trk_state_e          state_d;
    logic [31:0]         base_q;
    logic [1:0]          base_dprv_q;
    logic [STAMP_W-1:0]  stamp_q;
    logic [DROP_W-1:0]   drop_q;
    logic [31:0]         chg_mask;
    logic                change;
    logic                base_load;
    logic                push;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;
    mstatus_rec_t        wr_rec;
    mstatus_rec_t        rd_rec;

    assign chg_mask = (mstatus_in ^ base_q) & WATCH_MASK;
    assign change   = (chg_mask != 32'h0) || (dprv_in != base_dprv_q);

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // flush wins over a same-cycle sample, which is then ignored.
    always_comb begin
        state_d   = state_q;
        base_load = 1'b0;
        push      = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        base_load = 1'b1;
                        state_d   = TRACK;
                    end
                end
                TRACK: begin
                    if (sample_valid) begin
                        base_load = 1'b1;
                        push      = change;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            base_q      <= '0;
            base_dprv_q <= '0;
        end else if (base_load) begin
            base_q      <= mstatus_in;
            base_dprv_q <= dprv_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) stamp_q <= '0;
        else          stamp_q <= stamp_q + 1'b1;
    end

    assign pop  = rec_valid && rec_ready;
    assign drop = push && full && !pop;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    always_comb begin
        wr_rec        = '0;
        wr_rec.old_st = base_q;
        wr_rec.new_st = mstatus_in;
        wr_rec.mask   = chg_mask;
        wr_rec.dprv   = dprv_in;
        wr_rec.stamp  = STAMP_MAX_W'(stamp_q);
    end

    mstatus_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .wdata   (wr_rec),
        .pop     (pop),
        .rdata   (rd_rec),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign rec_valid  = !empty;
    assign rec_old    = rd_rec.old_st;
    assign rec_new    = rd_rec.new_st;
    assign rec_mask   = rd_rec.mask;
    assign rec_dprv   = rd_rec.dprv;
    assign rec_stamp  = rd_rec.stamp[STAMP_W-1:0];
    assign drop_count = drop_q;

    generate
        if (STAMP_W < STAMP_MAX_W) begin : g_stamp_pad
            logic unused_stamp_hi;
            assign unused_stamp_hi = ^rd_rec.stamp[STAMP_MAX_W-1:STAMP_W];
        end
    endgenerate

`ifdef MSTATUS_TRACE_LEGAL_CHECK_EN
    logic illegal_q;

    // Checked in both states; a flushed sample is not checked.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            illegal_q <= 1'b0;
        end else if (sample_valid && is_illegal(mstatus_in)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_seen = illegal_q;
`else
    assign illegal_seen = 1'b0;
`endif

endmodule

// File: tb/tb_mstatus_change_tracker.sv
// Randomized and directed bench for mstatus_change_tracker.
// Compares DUT outputs each cycle against a queue-based reference model.
module tb_mstatus_change_tracker;

    localparam int          DEPTH = 8;
    localparam logic [31:0] WM    = 32'h007F_FFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        sample_valid;
    logic [31:0] mstatus_in;
    logic [1:0]  dprv_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_old;
    logic [31:0] rec_new;
    logic [31:0] rec_mask;
    logic [1:0]  rec_dprv;
    logic [31:0] rec_stamp;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;
    logic        illegal_seen;

    always #5 clock = ~clock;

    mstatus_change_tracker #(
        .DEPTH      (DEPTH),
        .STAMP_W    (32),
        .WATCH_MASK (WM),
        .DROP_W     (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .sample_valid (sample_valid),
        .mstatus_in   (mstatus_in),
        .dprv_in      (dprv_in),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_old      (rec_old),
        .rec_new      (rec_new),
        .rec_mask     (rec_mask),
        .rec_dprv     (rec_dprv),
        .rec_stamp    (rec_stamp),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .illegal_seen (illegal_seen)
    );

    typedef struct {
        logic [31:0] o;
        logic [31:0] n;
        logic [31:0] m;
        logic [1:0]  d;
        logic [31:0] s;
    } rec_t;

    rec_t        q[$];
    bit          m_idle;
    logic [31:0] m_base;
    logic [1:0]  m_bdp;
    logic [31:0] m_stamp;
    int          m_drop;
    bit          m_ill;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_bad(input logic [31:0] ms);
        return (ms[12:11] == 2'b10) || (ms[30:23] != 8'h0);
    endfunction

    task automatic model_edge();
        rec_t r;
        bit   pop;
        if (!reset_n) begin
            q.delete();
            m_idle  = 1;
            m_base  = 0;
            m_bdp   = 0;
            m_stamp = 0;
            m_drop  = 0;
            m_ill   = 0;
            return;
        end
        pop = (q.size() != 0) && rec_ready;
        if (flush) begin
            q.delete();
            m_idle = 1;
            m_base = 0;
            m_bdp  = 0;
            m_ill  = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (sample_valid) begin
`ifdef MSTATUS_TRACE_LEGAL_CHECK_EN
                if (legal_bad(mstatus_in)) m_ill = 1;
`endif
                if (!m_idle && ((((mstatus_in ^ m_base) & WM) != 0) ||
                                (dprv_in != m_bdp))) begin
                    r.o = m_base;
                    r.n = mstatus_in;
                    r.m = (m_base ^ mstatus_in) & WM;
                    r.d = dprv_in;
                    r.s = m_stamp;
                    if (q.size() < DEPTH) q.push_back(r);
                    else if (m_drop < 65535) m_drop++;
                end
                m_base = mstatus_in;
                m_bdp  = dprv_in;
                m_idle = 0;
            end
        end
        m_stamp = m_stamp + 1;
    endtask

    task automatic compare();
        check("valid", rec_valid, q.size() != 0);
        check("level", fifo_level, q.size());
        check("drops", drop_count, m_drop);
        check("illegal", illegal_seen, m_ill);
        if (q.size() != 0) begin
            check("old", rec_old, q[0].o);
            check("new", rec_new, q[0].n);
            check("mask", rec_mask, q[0].m);
            check("dprv", rec_dprv, q[0].d);
            check("stamp", rec_stamp, q[0].s);
        end
    endtask

    task automatic step(input bit rn, input bit sv, input bit fl,
                        input bit rd, input logic [31:0] ms,
                        input logic [1:0] dp);
        reset_n      = rn;
        sample_valid = sv;
        flush        = fl;
        rec_ready    = rd;
        mstatus_in   = ms;
        dprv_in      = dp;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    logic [31:0] pool [4];

    initial begin
        logic [31:0] ms;
        pool[0] = 32'h0000_1800;
        pool[1] = 32'h0000_1808;
        pool[2] = 32'h0000_0000;
        pool[3] = 32'h0000_1888;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_valid", rec_valid, 1'b0);
        check("rst_level", fifo_level, 4'd0);

        step(1, 1, 0, 0, 32'h1800, 2'd3);
        check("base_norec", fifo_level, 4'd0);
        step(1, 1, 0, 0, 32'h1808, 2'd3);
        check("t1_mask", rec_mask, 32'h8);
        check("t1_old", rec_old, 32'h1800);
        check("t1_stamp", rec_stamp, 32'd1);
        step(1, 0, 0, 1, 0, 0);

        step(1, 1, 0, 0, 32'h1808, 2'd3);
        step(1, 1, 0, 0, 32'h1808, 2'd3);
        check("same_norec", fifo_level, 4'd0);
        step(1, 1, 0, 0, 32'h1808, 2'd0);
        check("dprv_mask", rec_mask, 32'h0);
        check("dprv_val", rec_dprv, 2'd0);
        step(1, 0, 0, 1, 0, 0);

        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 0, (i % 2) ? 32'h1808 : 32'h1800, 2'd0);
        check("full_level", fifo_level, 4'd8);
        check("full_drops", drop_count, 16'd2);
        step(1, 1, 0, 1, 32'h1800, 2'd0);
        check("pp_level", fifo_level, 4'd8);
        check("pp_drops", drop_count, 16'd2);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, 0);
        check("drained", fifo_level, 4'd0);

        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, (i % 2) ? 32'h1800 : 32'h1808, 2'd0);
        check("q3", fifo_level, 4'd3);
        step(1, 1, 1, 0, 32'h1808, 2'd0);
        check("flush_lvl", fifo_level, 4'd0);
        step(1, 1, 0, 0, 32'h1234, 2'd1);
        check("rebase", fifo_level, 4'd0);
        step(1, 1, 0, 0, 32'h123C, 2'd1);
        check("post_rebase", fifo_level, 4'd1);

        step(1, 1, 0, 1, 32'h1000, 2'd1);
`ifdef MSTATUS_TRACE_LEGAL_CHECK_EN
        check("ill_set", illegal_seen, 1'b1);
`else
        check("ill_off", illegal_seen, 1'b0);
`endif
        step(1, 1, 0, 1, 32'h1800, 2'd1);
        step(1, 0, 1, 1, 0, 0);
        check("ill_clr", illegal_seen, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            ms = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0)
                ms = ms ^ (32'h1 << $urandom_range(0, 31));
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0,
                 ms, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
